// File: rtl/compare_search_pkg.sv
// Shared types and helpers for the compare-search block.
// The search walks an offset-binary code; probe_map turns that code into
// the value driven on the comparator (flip the MSB for two's complement).
package compare_search_pkg;

  // Widest operand probe_map can handle; operands are left-aligned into it.
  localparam int MAX_BITS = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // u is left-aligned, so the operand MSB is always bit MAX_BITS-1.
  function automatic logic [MAX_BITS-1:0] probe_map(input logic [MAX_BITS-1:0] u,
                                                     input logic twosComplement);
    probe_map = u;
    if (twosComplement) probe_map[MAX_BITS-1] = ~u[MAX_BITS-1];
  endfunction

endpackage

// File: rtl/compare_search_probe_map.sv
// Combinational offset-code to probe-value mapping, reusable by any
// bisection block that has to present ordered values to a comparator.
module compare_search_probe_map
  import compare_search_pkg::*;
#(
  parameter int nrOfBits       = 8,
  parameter bit twosComplement = 1'b1
) (
  input  logic [nrOfBits-1:0] u,
  output logic [nrOfBits-1:0] probe
);

  logic [MAX_BITS-1:0] u_wide;
  logic [MAX_BITS-1:0] probe_wide;

  assign u_wide     = MAX_BITS'(u) << (MAX_BITS - nrOfBits);
  assign probe_wide = probe_map(u_wide, twosComplement);
  assign probe      = probe_wide[MAX_BITS-1 -: nrOfBits];

  // Low padding bits carry no information once the operand is sliced back out.
  generate
    if (nrOfBits < MAX_BITS) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^probe_wide[MAX_BITS-nrOfBits-1:0];
    end
  endgenerate

endmodule

// File: rtl/compare_search_sequencer.sv
// Successive-approximation search driving an external comparator's dataA.
// One probe per cycle; flags from the combinational comparator are sampled
// on the edge ending the cycle the probe is shown.
// Optional feature: define COMPARE_SEARCH_EARLY_EXIT_EN to stop as soon as
// the comparator reports equality.
module compare_search_sequencer
  import compare_search_pkg::*;
#(
  parameter int nrOfBits       = 8,
  parameter int twosComplement = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          aEqualsB,
  input  logic                          aGreaterThanB,
  input  logic                          aLessThanB,
  output logic [nrOfBits-1:0]           dataA,
  output logic                          busy,
  output logic                          done,
  output logic [nrOfBits-1:0]           result,
  output logic                          error,
  output logic [$clog2(nrOfBits+1)-1:0] probeCount
);

  localparam int IW = (nrOfBits > 1) ? $clog2(nrOfBits) : 1;
  localparam int CW = $clog2(nrOfBits + 1);
  localparam logic [nrOfBits-1:0] TOP_U    = nrOfBits'(1) << (nrOfBits - 1);
  localparam logic [IW-1:0]       LAST_IDX = IW'(nrOfBits - 1);

  state_t              state, state_nxt;
  logic [nrOfBits-1:0] u, u_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [IW-1:0]       idx_dec;
  logic [nrOfBits-1:0] data_nxt, result_nxt;
  logic                error_nxt;
  logic [CW-1:0]       count_nxt;
  logic                flags_ok;
  logic [nrOfBits-1:0] u_clr, u_set, u_probe;
  logic [nrOfBits-1:0] probe_next, probe_final;

  assign busy     = (state == SEARCH);
  assign done     = (state == DONE);
  assign flags_ok = $onehot({aEqualsB, aGreaterThanB, aLessThanB});
  assign idx_dec  = idx - IW'(1);

  // Resolve the current bit, then pre-set the next one as the new trial bit.
  always_comb begin
    u_clr = u;
    if (aGreaterThanB) u_clr[idx] = 1'b0;
    u_set = u_clr;
    if (idx != '0) u_set[idx_dec] = 1'b1;
  end

  assign u_probe = (state == IDLE) ? TOP_U : u_set;

  compare_search_probe_map #(
    .nrOfBits       (nrOfBits),
    .twosComplement (twosComplement != 0)
  ) u_map_next (
    .u     (u_probe),
    .probe (probe_next)
  );

  compare_search_probe_map #(
    .nrOfBits       (nrOfBits),
    .twosComplement (twosComplement != 0)
  ) u_map_final (
    .u     (u_clr),
    .probe (probe_final)
  );

  // Next-state and datapath updates; everything holds unless the state acts.
  always_comb begin
    state_nxt  = state;
    u_nxt      = u;
    idx_nxt    = idx;
    data_nxt   = dataA;
    result_nxt = result;
    error_nxt  = error;
    count_nxt  = probeCount;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SEARCH;
          u_nxt      = TOP_U;
          idx_nxt    = LAST_IDX;
          data_nxt   = probe_next;
          result_nxt = '0;
          error_nxt  = 1'b0;
          count_nxt  = '0;
        end
      end
      SEARCH: begin
        count_nxt = probeCount + CW'(1);
        if (!flags_ok) begin
          error_nxt  = 1'b1;
          result_nxt = '0;
          state_nxt  = DONE;
        end
`ifdef COMPARE_SEARCH_EARLY_EXIT_EN
        else if (aEqualsB) begin
          result_nxt = dataA;
          state_nxt  = DONE;
        end
`endif
        else if (idx == '0) begin
          u_nxt      = u_clr;
          result_nxt = probe_final;
          state_nxt  = DONE;
        end else begin
          idx_nxt  = idx_dec;
          u_nxt    = u_set;
          data_nxt = probe_next;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      u          <= '0;
      idx        <= '0;
      dataA      <= '0;
      result     <= '0;
      error      <= 1'b0;
      probeCount <= '0;
    end else begin
      state      <= state_nxt;
      u          <= u_nxt;
      idx        <= idx_nxt;
      dataA      <= data_nxt;
      result     <= result_nxt;
      error      <= error_nxt;
      probeCount <= count_nxt;
    end
  end

endmodule

// File: tb/tb_compare_search_sequencer.sv
// Directed bench: an unsigned and a signed sequencer, each paired with a
// behavioural comparator against a hidden operand.
module tb_compare_search_sequencer;

`ifdef COMPARE_SEARCH_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct {
    bit         tc;
    logic [7:0] b;
    logic [7:0] first;
    int         kill;
    logic [7:0] res;
    bit         err;
    int         cnt;
    int         lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start_u, start_s, kill, sel;
  logic [7:0] hidden;

  logic [7:0] dataA_u, result_u, dataA_s, result_s;
  logic       busy_u, done_u, error_u, busy_s, done_s, error_s;
  logic [3:0] count_u, count_s;
  logic       eq_u, gt_u, lt_u, eq_s, gt_s, lt_s;

  logic       s_done, s_busy, s_error;
  logic [7:0] s_dataA, s_result;
  logic [3:0] s_count;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  // Behavioural comparators; kill forces all flags low.
  always_comb begin
    eq_u = !kill && (dataA_u == hidden);
    gt_u = !kill && (dataA_u > hidden);
    lt_u = !kill && (dataA_u < hidden);
    eq_s = !kill && (dataA_s == hidden);
    gt_s = !kill && ($signed(dataA_s) > $signed(hidden));
    lt_s = !kill && ($signed(dataA_s) < $signed(hidden));
  end

  assign s_done   = sel ? done_s   : done_u;
  assign s_busy   = sel ? busy_s   : busy_u;
  assign s_error  = sel ? error_s  : error_u;
  assign s_dataA  = sel ? dataA_s  : dataA_u;
  assign s_result = sel ? result_s : result_u;
  assign s_count  = sel ? count_s  : count_u;

  always @(posedge clk) if (done_u) done_pulses <= done_pulses + 1;

  compare_search_sequencer #(.nrOfBits(8), .twosComplement(0)) dut_u (
    .clock(clk), .reset(rst), .start(start_u),
    .aEqualsB(eq_u), .aGreaterThanB(gt_u), .aLessThanB(lt_u),
    .dataA(dataA_u), .busy(busy_u), .done(done_u), .result(result_u),
    .error(error_u), .probeCount(count_u));

  compare_search_sequencer #(.nrOfBits(8), .twosComplement(1)) dut_s (
    .clock(clk), .reset(rst), .start(start_s),
    .aEqualsB(eq_s), .aGreaterThanB(gt_s), .aLessThanB(lt_s),
    .dataA(dataA_s), .busy(busy_s), .done(done_s), .result(result_s),
    .error(error_s), .probeCount(count_s));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Starts from an IDLE cycle (at negedge) and returns in the IDLE cycle after done.
  task automatic run(input int n, input vec_t v);
    int cyc;
    bit got;
    sel = v.tc; hidden = v.b; kill = 1'b0;
    if (v.tc) start_s = 1'b1; else start_u = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0; start_u = 1'b0;
    check($sformatf("v%0d_first_probe", n), s_dataA, v.first);
    cyc = 1; got = 1'b0;
    while (!got && cyc <= 20) begin
      kill = (cyc == v.kill);
      if (s_done) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    kill = 1'b0;
    check($sformatf("v%0d_done_seen", n), got, 1);
    check($sformatf("v%0d_latency", n), cyc, v.lat);
    check($sformatf("v%0d_result", n), s_result, v.res);
    check($sformatf("v%0d_error", n), s_error, v.err);
    check($sformatf("v%0d_probe_count", n), s_count, v.cnt);
    @(negedge clk);
    check($sformatf("v%0d_idle_after", n), {s_done, s_busy}, 2'b00);
  endtask

  vec_t       vecs[9];
  logic [7:0] seq[8];

  initial begin
    int pulses;
    int cyc;
    bit got;
    rst = 1'b1; start_u = 1'b0; start_s = 1'b0; kill = 1'b0; sel = 1'b0; hidden = 8'h00;

    vecs[0] = '{1'b0, 8'hA5, 8'h80, 0, 8'hA5, 1'b0, 8, 9};
    vecs[1] = '{1'b1, 8'hFD, 8'h00, 0, 8'hFD, 1'b0, 8, 9};
    vecs[2] = '{1'b0, 8'h80, 8'h80, 0, 8'h80, 1'b0, EE ? 1 : 8, EE ? 2 : 9};
    vecs[3] = '{1'b0, 8'h00, 8'h80, 0, 8'h00, 1'b0, 8, 9};
    vecs[4] = '{1'b0, 8'hFF, 8'h80, 0, 8'hFF, 1'b0, 8, 9};
    vecs[5] = '{1'b1, 8'h80, 8'h00, 0, 8'h80, 1'b0, 8, 9};
    vecs[6] = '{1'b0, 8'hA5, 8'h80, 3, 8'h00, 1'b1, 3, 4};
    vecs[7] = '{1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, EE ? 1 : 8, EE ? 2 : 9};
    vecs[8] = '{1'b1, 8'h7F, 8'h00, 0, 8'h7F, 1'b0, 8, 9};
    seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_unsigned", {dataA_u, busy_u, done_u, result_u, error_u, count_u}, 0);
    check("reset_signed", {dataA_s, busy_s, done_s, result_s, error_s, count_s}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Probe sequence for unsigned 0xA5.
    sel = 1'b0; hidden = 8'hA5; start_u = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_u = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("probe_seq_%0d", c), {busy_u, dataA_u}, {1'b1, seq[c]});
      @(negedge clk);
    end
    check("probe_seq_done", {done_u, result_u}, {1'b1, 8'hA5});
    @(negedge clk);
    check("probe_seq_hold", dataA_u, 8'hA5);

    for (int n = 0; n < 9; n++) run(n, vecs[n]);

    // Reset in the middle of a search.
    sel = 1'b0; hidden = 8'hA5; start_u = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_u = 1'b0;
    pulses = done_pulses;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midreset_outputs", {dataA_u, busy_u, done_u, result_u, error_u, count_u}, 0);
    repeat (12) @(negedge clk);
    check("midreset_no_done", done_pulses - pulses, 0);
    check("midreset_stays_idle", busy_u, 1'b0);
    run(100, vecs[0]);

    // A start pulsed mid-search is neither restarting nor queued.
    sel = 1'b0; hidden = 8'hA5; start_u = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_u = 1'b0;
    @(negedge clk);
    start_u = 1'b1;
    @(negedge clk);
    start_u = 1'b0;
    cyc = 3; got = 1'b0;
    while (!got && cyc <= 20) begin
      if (done_u) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("busy_start_latency", cyc, 9);
    check("busy_start_result", {error_u, result_u, count_u}, {1'b0, 8'hA5, 4'd8});
    @(negedge clk);
    check("busy_start_not_queued_1", {busy_u, done_u}, 2'b00);
    @(negedge clk);
    check("busy_start_not_queued_2", {busy_u, done_u}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
